// File: rtl/melody_sequencer.sv
// Song-table melody sequencer: plays up to 16 {note, duration} entries as one-hot
// note enables, with a silent gap closing every step and optional looping.
module melody_sequencer #(
    parameter int unsigned BEAT_CYCLES = 6250000,
    parameter int unsigned GAP_CYCLES  = 250000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_loop_en,
    input  logic       i_wr_en,
    input  logic [3:0] i_wr_addr,
    input  logic [6:0] i_wr_data,
    output logic [5:0] o_note_en,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_step_idx
);

    localparam int unsigned CNT_W   = 40;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned NOTE_W  = 6;
    localparam int unsigned ENTRY_W = 7;
    localparam int unsigned DEPTH   = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [NOTE_W-1:0]    r_note;
    logic [NOTE_W-1:0]    w_note_nxt;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_end;
    logic [ENTRY_W-1:0]   r_table [DEPTH];

    logic [ENTRY_W-1:0]   w_entry;
    logic [2:0]           w_note;
    logic [3:0]           w_dur;
    logic [NOTE_W-1:0]    w_onehot;
    logic [CNT_W-1:0]     w_play_len;

    assign w_entry    = r_table[r_idx];
    assign w_note     = w_entry[6:4];
    assign w_dur      = w_entry[3:0];
    // 40-bit product keeps 15 * BEAT_CYCLES exact for any 32-bit BEAT_CYCLES
    assign w_play_len = CNT_W'(w_dur) * CNT_W'(BEAT_CYCLES) - CNT_W'(GAP_CYCLES);

    // Notes 1..6 map to C..A; 0 and 7 are rests
    always_comb begin
        w_onehot = '0;
        if (w_note >= 3'd1 && w_note <= 3'd6) begin
            w_onehot = NOTE_W'(1) << (w_note - 3'd1);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_note_nxt  = r_note;
        w_done_nxt  = 1'b0;
        w_end       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_note_nxt = '0;
                if (i_start) begin
                    w_state_nxt = S_FETCH;
                    w_idx_nxt   = '0;
                end
            end
            S_FETCH: begin
                if (w_dur != 4'd0) begin
                    w_state_nxt = S_PLAY;
                    w_cnt_nxt   = w_play_len - CNT_W'(1);
                    w_note_nxt  = w_onehot;
                end else begin
                    w_end = 1'b1;
                end
            end
            S_PLAY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = CNT_W'(GAP_CYCLES) - CNT_W'(1);
                    w_note_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_GAP: begin
                w_note_nxt = '0;
                if (r_cnt == '0) begin
                    if (r_idx != IDX_W'(DEPTH - 1)) begin
                        w_state_nxt = S_FETCH;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                    end else begin
                        w_end = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_note_nxt  = '0;
            end
        endcase

        // An end marker at entry 0 would loop forever, so it always completes
        if (w_end) begin
            w_note_nxt = '0;
            w_idx_nxt  = '0;
            if (i_loop_en && r_idx != '0) begin
                w_state_nxt = S_FETCH;
            end else begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
        end

        if (i_stop) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_note_nxt  = '0;
            w_done_nxt  = 1'b0;
        end
    end

    // State, outputs and song table; reset also clears the table
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_note  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_note  <= w_note_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
            if (r_state == S_IDLE && i_wr_en) begin
                r_table[i_wr_addr] <= i_wr_data;
            end
        end
    end

    assign o_note_en  = r_note;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_step_idx = r_idx;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: per-cycle expected outputs are queued
// as stimulus is applied and compared on the falling edge.
module tb_melody_sequencer;

    localparam int unsigned BEAT = 10;
    localparam int unsigned GAP  = 2;

    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
    logic       i_loop_en = 1'b0;
    logic       i_wr_en = 1'b0;
    logic [3:0] i_wr_addr = '0;
    logic [6:0] i_wr_data = '0;
    logic [5:0] o_note_en;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_step_idx;

    melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_loop_en  (i_loop_en),
        .i_wr_en    (i_wr_en),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .o_note_en  (o_note_en),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_step_idx (o_step_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] note;
        logic       busy;
        logic       done;
        logic [3:0] idx;
    } exp_t;

    typedef struct {
        logic [2:0] note;
        logic [3:0] dur;
        logic [5:0] exp_oh;
    } vec_t;

    exp_t q[$];
    vec_t vecs[8];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input exp_t e, input string name);
        n_tests++;
        if (o_note_en !== e.note || o_busy !== e.busy || o_done !== e.done || o_step_idx !== e.idx) begin
            n_fail++;
            $display("FAIL %s @%0t: got note=%b busy=%b done=%b idx=%0d, want note=%b busy=%b done=%b idx=%0d",
                     name, $time, o_note_en, o_busy, o_done, o_step_idx, e.note, e.busy, e.done, e.idx);
        end
    endtask

    task automatic push(input logic [5:0] n, input logic b, input logic d, input logic [3:0] i, input int cnt);
        exp_t e;
        e.note = n; e.busy = b; e.done = d; e.idx = i;
        repeat (cnt) q.push_back(e);
    endtask

    // FETCH, then dur*BEAT-GAP cycles of the note, then GAP silent cycles
    task automatic push_step(input logic [5:0] n, input int dur, input logic [3:0] i);
        push(6'd0, 1'b1, 1'b0, i, 1);
        push(n, 1'b1, 1'b0, i, dur * BEAT - GAP);
        push(6'd0, 1'b1, 1'b0, i, GAP);
    endtask

    task automatic push_end(input logic [3:0] i);
        push(6'd0, 1'b1, 1'b0, i, 1);
        push(6'd0, 1'b0, 1'b1, 4'd0, 1);
        push(6'd0, 1'b0, 1'b0, 4'd0, 1);
    endtask

    task automatic drain(input string name);
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            check(e, name);
            if (q.size() > 0) @(negedge clk);
        end
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [6:0] d);
        i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
        @(negedge clk);
        i_wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    function automatic logic [5:0] note_oh(input int n);
        case (n)
            1: note_oh = 6'b000001;
            2: note_oh = 6'b000010;
            3: note_oh = 6'b000100;
            4: note_oh = 6'b001000;
            5: note_oh = 6'b010000;
            6: note_oh = 6'b100000;
            default: note_oh = 6'b000000;
        endcase
    endfunction

    initial begin
        exp_t idle;
        idle.note = 6'd0; idle.busy = 1'b0; idle.done = 1'b0; idle.idx = 4'd0;

        vecs[0] = '{3'd1, 4'd1, 6'b000001};
        vecs[1] = '{3'd2, 4'd1, 6'b000010};
        vecs[2] = '{3'd3, 4'd2, 6'b000100};
        vecs[3] = '{3'd4, 4'd1, 6'b001000};
        vecs[4] = '{3'd5, 4'd1, 6'b010000};
        vecs[5] = '{3'd6, 4'd3, 6'b100000};
        vecs[6] = '{3'd0, 4'd1, 6'b000000};
        vecs[7] = '{3'd7, 4'd2, 6'b000000};

        repeat (3) @(negedge clk);
        check(idle, "reset");
        i_reset = 1'b1;
        @(negedge clk);
        check(idle, "idle_after_reset");

        // Single-step songs over every note code
        for (int v = 0; v < 8; v++) begin
            write_entry(4'd0, {vecs[v].note, vecs[v].dur});
            write_entry(4'd1, 7'd0);
            pulse_start();
            push_step(vecs[v].exp_oh, int'(vecs[v].dur), 4'd0);
            push_end(4'd1);
            drain($sformatf("vec%0d", v));
        end

        // {C,1},{E,2},{end}
        write_entry(4'd0, {3'd1, 4'd1});
        write_entry(4'd1, {3'd3, 4'd2});
        write_entry(4'd2, 7'd0);
        pulse_start();
        push_step(6'b000001, 1, 4'd0);
        push_step(6'b000100, 2, 4'd1);
        push_end(4'd2);
        drain("song_ce");

        // Looping: end-marker FETCH leads straight back to entry 0, then stop
        i_loop_en = 1'b1;
        @(negedge clk);
        pulse_start();
        push_step(6'b000001, 1, 4'd0);
        push_step(6'b000100, 2, 4'd1);
        push(6'd0, 1'b1, 1'b0, 4'd2, 1);
        push_step(6'b000001, 1, 4'd0);
        push(6'd0, 1'b1, 1'b0, 4'd1, 1);
        push(6'b000100, 1'b1, 1'b0, 4'd1, 3);
        drain("loop");
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        check(idle, "loop_stop");
        @(negedge clk);
        check(idle, "loop_stop_hold");
        i_loop_en = 1'b0;

        // Full 16-entry table with rest first; completes after entry 15
        for (int i = 0; i < 16; i++) begin
            int n;
            n = (i == 0) ? 7 : (i == 1) ? 6 : ((i - 2) % 6) + 1;
            write_entry(4'(i), {3'(n), 4'd1});
        end
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            int n;
            n = (i == 0) ? 7 : (i == 1) ? 6 : ((i - 2) % 6) + 1;
            push_step(note_oh(n), 1, 4'(i));
        end
        push(6'd0, 1'b0, 1'b1, 4'd0, 1);
        push(6'd0, 1'b0, 1'b0, 4'd0, 1);
        drain("full16");

        // Writes and start while busy are ignored
        write_entry(4'd0, {3'd2, 4'd1});
        write_entry(4'd1, 7'd0);
        pulse_start();
        push_step(6'b000010, 1, 4'd0);
        push_end(4'd1);
        fork
            drain("busy_wr");
            begin
                repeat (2) @(negedge clk);
                i_wr_en = 1'b1; i_wr_addr = 4'd0; i_wr_data = {3'd4, 4'd1};
                @(negedge clk);
                i_wr_addr = 4'd1; i_wr_data = {3'd6, 4'd2}; i_start = 1'b1;
                @(negedge clk);
                i_wr_en = 1'b0; i_start = 1'b0;
            end
        join
        @(negedge clk);
        pulse_start();
        push_step(6'b000010, 1, 4'd0);
        push_end(4'd1);
        drain("replay");

        // start and stop together: stop wins
        i_start = 1'b1; i_stop = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_stop = 1'b0;
        check(idle, "start_stop");
        @(negedge clk);
        check(idle, "start_stop_hold");

        // Write and start in the same cycle: FETCH sees the new entry
        i_wr_en = 1'b1; i_wr_addr = 4'd0; i_wr_data = {3'd5, 4'd1}; i_start = 1'b1;
        @(negedge clk);
        i_wr_en = 1'b0; i_start = 1'b0;
        push_step(6'b010000, 1, 4'd0);
        push_end(4'd1);
        drain("wr_start");

        // Reset mid-PLAY clears the table, so the next start completes at once
        write_entry(4'd0, {3'd5, 4'd3});
        pulse_start();
        push(6'd0, 1'b1, 1'b0, 4'd0, 1);
        push(6'b010000, 1'b1, 1'b0, 4'd0, 10);
        drain("pre_reset");
        i_reset = 1'b0;
        @(negedge clk);
        i_reset = 1'b1;
        check(idle, "mid_reset");
        @(negedge clk);
        pulse_start();
        push(6'd0, 1'b1, 1'b0, 4'd0, 1);
        push(6'd0, 1'b0, 1'b1, 4'd0, 1);
        push(6'd0, 1'b0, 1'b0, 4'd0, 1);
        drain("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 Parameter BEAT_CYCLES, default 6250000, clk cycles per beat (250 ms at 25 MHz); SHALL be > GAP_CYCLES.
REQ-002 Parameter GAP_CYCLES, default 250000, silent cycles closing every step (10 ms at 25 MHz); SHALL be >= 1.
REQ-003 clk  input  1  system clock, 25 MHz; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 start  input  1  one-cycle request to begin playback from entry 0.
REQ-006 stop  input  1  abort playback.
REQ-007 loop_en  input  1  when 1, restart at entry 0 on reaching end of song.
REQ-008 wr_en  input  1  write strobe for the song table.
REQ-009 wr_addr  input  4  song-table entry index, 0..15.
REQ-010 wr_data  input  7  {note[6:4], dur[3:0]}; note 1..6 = C,D,E,F,G,A; note 0 or 7 = rest; dur in beats, 0 = end marker.
REQ-011 note_en  output  6  one-hot note enables (bit0 C ... bit5 A), feeds AudioGenerator note_en.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on natural song completion.
REQ-014 step_idx  output  4  index of the entry currently fetched or playing.

Function
REQ-015 Song table SHALL be 16 x 7-bit registers, written only in IDLE; wr_en outside IDLE is ignored.
REQ-016 States SHALL be IDLE, FETCH, PLAY, GAP.
REQ-017 IDLE: note_en=0, busy=0. start=1 -> FETCH with step_idx=0.
REQ-018 FETCH (exactly one cycle, note_en=0): read entry[step_idx].
- dur!=0 -> PLAY; note_en = one-hot(note), or 0 for a rest.
- dur==0 -> end of song (REQ-021).
REQ-019 PLAY SHALL last dur*BEAT_CYCLES-GAP_CYCLES cycles with note_en constant, then -> GAP.
REQ-020 GAP SHALL last GAP_CYCLES cycles with note_en=0. Then:
- step_idx<15 -> step_idx+1, FETCH.
- step_idx==15 -> end of song.
REQ-021 End of song: loop_en=1 and step_idx!=0 -> step_idx=0, FETCH. Otherwise -> IDLE with done=1 for one cycle. A dur==0 entry at index 0 SHALL never loop.
REQ-022 A step with nonzero dur SHALL occupy exactly dur*BEAT_CYCLES+1 cycles (FETCH+PLAY+GAP).
REQ-023 Latency: start sampled at edge k in IDLE -> FETCH during cycle k+1 -> note_en valid from edge k+2.
REQ-024 start while busy SHALL be ignored.
REQ-025 stop=1 in any state SHALL force IDLE at the next edge: note_en=0, busy=0, done=0, table retained.
REQ-026 stop and start in the same cycle: stop wins.
REQ-027 wr_en and start in the same IDLE cycle: write commits first, and the following FETCH sees the new data.
REQ-028 Cycle counter SHALL be at least 32 bits; dur*BEAT_CYCLES SHALL be computed without overflow for dur=15.
REQ-029 note_en SHALL be registered, glitch-free, and never have more than one bit set.

Reset
REQ-030 reset=0 at a clk edge SHALL force IDLE, note_en=0, busy=0, done=0, step_idx=0, and all table entries to 0. This holds mid-step and takes priority over start, stop and wr_en.

Verification
REQ-031 Test parameters BEAT_CYCLES=10, GAP_CYCLES=2 for all scenarios below.
REQ-032 Table {C,1},{E,2},{0,0}; start pulse:
- note_en=000001 for 8 cycles from edge k+2, then 0 for 3 cycles.
- note_en=000100 for 18 cycles, then 0 for 3 cycles.
- done pulses once; busy falls with it.
REQ-033 Same table, loop_en=1: after the E gap and the end-marker FETCH, note_en=000001 resumes with no done pulse. stop then gives IDLE and note_en=0 next edge.
REQ-034 Entries {7,1},{A,1}, all 16 entries nonzero: rest yields note_en=0 for a full step. After entry 15 with loop_en=0, done=1 and step_idx returns 0.
REQ-035 wr_en while busy leaves the table unchanged (readback by replay). start while busy does not restart. start+stop together stays IDLE.
REQ-036 reset=0 during PLAY of {G,3}: next edge note_en=0, busy=0, and a following start with no writes gives immediate done (entry 0 cleared to end marker).
